// File: rtl/io_input_ctrl_if.sv
// Memory-mapped load/store port of io_input_ctrl; the core drives the master side.
interface io_input_ctrl_if;
  logic [2:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvld;

  modport master (output addr, rd, wr, wdata, input rdata, rvld);
  modport slave  (input addr, rd, wr, wdata, output rdata, rvld);
endinterface

// File: rtl/io_input_ctrl.sv
// Switch/button input controller: synchronise, debounce, sticky press/release events,
// maskable interrupt and a small register file with a one-cycle read.
module io_input_ctrl #(
  parameter int N_SW            = 32,
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit SW_DEBOUNCE     = 1'b1,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SW-1:0]  i_io_sw,
  input  logic [N_BTN-1:0] i_io_btn,
  io_input_ctrl_if.slave   bus,
  output logic             o_irq
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    A_SW     = 3'd0;
  localparam logic [2:0]    A_BTN    = 3'd1;
  localparam logic [2:0]    A_PRESS  = 3'd2;
  localparam logic [2:0]    A_REL    = 3'd3;
  localparam logic [2:0]    A_IRQEN  = 3'd4;

  logic [SYNC_STAGES-1:0][N_SW-1:0]  sw_sync_q, sw_sync_d;
  logic [SYNC_STAGES-1:0][N_BTN-1:0] btn_sync_q, btn_sync_d;
  logic [N_BTN-1:0]                  btn_pin;
  logic [N_SW-1:0]                   sw_s, sw_st_q, sw_st_d;
  logic [N_BTN-1:0]                  btn_s, btn_st_q, btn_st_d;
  logic [N_BTN-1:0][CW-1:0]          btn_cnt_q, btn_cnt_d;
  logic [N_BTN-1:0]                  press_q, press_d, release_q, release_d;
  logic [N_BTN-1:0]                  irq_en_q, irq_en_d, press_clr, release_clr;
  logic [31:0]                       rdata_q, rdata_d, rd_word;
  logic                              rvld_q, rvld_d;
  logic                              wdata_unused;

  assign btn_pin      = BTN_ACTIVE_LOW ? ~i_io_btn : i_io_btn;
  assign sw_s         = sw_sync_q[SYNC_STAGES-1];
  assign btn_s        = btn_sync_q[SYNC_STAGES-1];
  assign wdata_unused = ^bus.wdata;

  always_comb begin
    sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], i_io_sw};
    btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn_pin};
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    btn_st_d  = btn_st_q;
    btn_cnt_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_s[i] != btn_st_q[i]) begin
        if (btn_cnt_q[i] == CNT_LAST) begin
          btn_st_d[i] = btn_s[i];
        end else begin
          btn_cnt_d[i] = btn_cnt_q[i] + CW'(1);
        end
      end else begin
        btn_cnt_d[i] = '0;
      end
    end
  end

  generate
    if (SW_DEBOUNCE) begin : g_sw_db
      logic [N_SW-1:0][CW-1:0] sw_cnt_q, sw_cnt_d;

      always_comb begin
        sw_st_d  = sw_st_q;
        sw_cnt_d = '0;
        for (int i = 0; i < N_SW; i++) begin
          if (sw_s[i] != sw_st_q[i]) begin
            if (sw_cnt_q[i] == CNT_LAST) begin
              sw_st_d[i] = sw_s[i];
            end else begin
              sw_cnt_d[i] = sw_cnt_q[i] + CW'(1);
            end
          end else begin
            sw_cnt_d[i] = '0;
          end
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sw_cnt_q <= '0;
        end else begin
          sw_cnt_q <= sw_cnt_d;
        end
      end
    end else begin : g_sw_raw
      always_comb sw_st_d = sw_s;
    end
  endgenerate

  // Event set wins over a same-cycle write-1-to-clear; reads see pre-write values.
  always_comb begin
    press_clr   = (bus.wr && (bus.addr == A_PRESS)) ? bus.wdata[N_BTN-1:0] : '0;
    release_clr = (bus.wr && (bus.addr == A_REL))   ? bus.wdata[N_BTN-1:0] : '0;
    press_d     = (press_q & ~press_clr) | (btn_st_d & ~btn_st_q);
    release_d   = (release_q & ~release_clr) | (~btn_st_d & btn_st_q);
    irq_en_d    = (bus.wr && (bus.addr == A_IRQEN)) ? bus.wdata[N_BTN-1:0] : irq_en_q;
    case (bus.addr)
      A_SW:    rd_word = 32'(sw_st_q);
      A_BTN:   rd_word = 32'(btn_st_q);
      A_PRESS: rd_word = 32'(press_q);
      A_REL:   rd_word = 32'(release_q);
      A_IRQEN: rd_word = 32'(irq_en_q);
      default: rd_word = 32'd0;
    endcase
    rvld_d  = bus.rd;
    rdata_d = bus.rd ? rd_word : rdata_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_sync_q  <= '0;
      btn_sync_q <= '0;
      sw_st_q    <= '0;
      btn_st_q   <= '0;
      btn_cnt_q  <= '0;
      press_q    <= '0;
      release_q  <= '0;
      irq_en_q   <= '0;
      rdata_q    <= 32'd0;
      rvld_q     <= 1'b0;
    end else begin
      sw_sync_q  <= sw_sync_d;
      btn_sync_q <= btn_sync_d;
      sw_st_q    <= sw_st_d;
      btn_st_q   <= btn_st_d;
      btn_cnt_q  <= btn_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      irq_en_q   <= irq_en_d;
      rdata_q    <= rdata_d;
      rvld_q     <= rvld_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rvld  = rvld_q;
  assign o_irq     = |(press_q & irq_en_q);
endmodule
